and_chain_event_capture: RTL and testbench

- Downstream consumer of the AND2-chain stage's outputs: the 1-bit chain result O and the 2-bit tap bus O1.
- Measures each contiguous high run of the chain result and snapshots the tap bus at the start of the run.
- Queues one event record per run in a small FIFO.
- Delivers records over a valid/ready interface to a host-side reader.

---
 rtl/and_chain_event_capture.sv | 109 ++++++++++
 tb/tb_and_chain_event_capture.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/and_chain_event_capture.sv
`default_nettype none
// and_chain_event_capture: measures high runs of the AND2-chain result, snapshots the tap bus at
// run start and queues {snap, run_len} records in a FIFO drained over valid/ready.  Rev 1.0
module and_chain_event_capture #(
   parameter int CNT_WIDTH  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 CLK,
   input  logic                 RESETN,
   input  logic                 I,
   input  logic [1:0]           I1,
   input  logic                 CLEAR,
   output logic                 O_valid,
   input  logic                 O_ready,
   output logic [CNT_WIDTH+1:0] O_data,
   output logic                 OVERFLOW
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int REC_W = CNT_WIDTH + 2;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]       OCC_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]       OCC_FULL = (PTR_W + 1)'(FIFO_DEPTH);

   logic                 s_q;
   logic [1:0]           i1_q;
   logic [CNT_WIDTH-1:0] cnt;
   logic [1:0]           snap;
   logic                 overflow_q;

   logic [REC_W-1:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W:0]       occ;

   logic push;
   logic pop;
   logic empty;
   logic full;
   logic push_ok;
   logic drop;

   assign empty   = (occ == '0);
   assign full    = (occ == OCC_FULL);
   assign push    = !s_q && (cnt != '0);
   assign pop     = !empty && O_ready;
   // A full FIFO still accepts a record when the head leaves on the same edge.
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         s_q        <= 1'b0;
         i1_q       <= 2'b00;
         cnt        <= '0;
         snap       <= 2'b00;
         overflow_q <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occ        <= '0;
      end else begin
         s_q  <= I;
         i1_q <= I1;

         if (s_q) begin
            if (cnt != CNT_MAX) begin
               cnt <= cnt + 1'b1;
            end
            if (cnt == '0) begin
               snap <= i1_q;
            end
         end else begin
            cnt <= '0;
         end

         if (drop) begin
            overflow_q <= 1'b1;
         end else if (CLEAR) begin
            overflow_q <= 1'b0;
         end

         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push_ok, pop})
            2'b10:   occ <= occ + OCC_ONE;
            2'b01:   occ <= occ - OCC_ONE;
            default: occ <= occ;
         endcase
      end
   end

   // Storage needs no reset: an entry is only visible after it has been written.
   always_ff @(posedge CLK) begin
      if (RESETN && push_ok) begin
         mem[wr_ptr] <= {snap, cnt};
      end
   end

   assign O_valid  = !empty;
   assign O_data   = empty ? '0 : mem[rd_ptr];
   assign OVERFLOW = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_and_chain_event_capture.sv
`default_nettype none
// Directed bench for and_chain_event_capture: hand-computed records for single runs,
// backpressure ordering, overflow, saturation, full push+pop, reset mid-run and gaps.
module tb_and_chain_event_capture;

   logic       CLK;
   logic       RESETN;
   logic       I;
   logic [1:0] I1;
   logic       CLEAR;
   logic       O_valid;
   logic       O_ready;
   logic [9:0] O_data;
   logic       OVERFLOW;

   int tests_run = 0;
   int tests_failed = 0;

   and_chain_event_capture #(.CNT_WIDTH(8), .FIFO_DEPTH(4)) dut (
      .CLK      (CLK),
      .RESETN   (RESETN),
      .I        (I),
      .I1       (I1),
      .CLEAR    (CLEAR),
      .O_valid  (O_valid),
      .O_ready  (O_ready),
      .O_data   (O_data),
      .OVERFLOW (OVERFLOW)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Drives a run of len sampled-high cycles, then one low sample (edge k).
   task automatic do_run(input int len, input logic [1:0] s);
      I  = 1'b1;
      I1 = s;
      step();
      I1 = ~s;
      repeat (len - 1) step();
      I = 1'b0;
      step();
   endtask

   task automatic test_reset();
      RESETN = 1'b0;
      step();
      step();
      RESETN = 1'b1;
      tests_run++;
      if (O_valid !== 1'b0 || O_data !== 10'd0 || OVERFLOW !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: valid=%b data=%h ovf=%b, required 0/000/0", O_valid, O_data, OVERFLOW);
      end
   endtask

   task automatic test_single_run();
      O_ready = 1'b1;
      I  = 1'b1;
      I1 = 2'b10;
      step();
      I1 = 2'b01;
      step();
      step();
      I = 1'b0;
      step();
      tests_run++;
      if (O_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_early: valid=%b, required 0", O_valid);
      end
      step();
      tests_run++;
      if (O_valid !== 1'b1 || O_data !== {2'b10, 8'd3}) begin
         tests_failed++;
         $display("FAIL single_record: valid=%b data=%h, required 1/%h", O_valid, O_data, {2'b10, 8'd3});
      end
      step();
      tests_run++;
      if (O_valid !== 1'b0 || O_data !== 10'd0) begin
         tests_failed++;
         $display("FAIL single_popped: valid=%b data=%h, required 0/000", O_valid, O_data);
      end
   endtask

   task automatic test_backpressure();
      logic [9:0] exp_q [4];
      exp_q[0] = {2'd0, 8'd1};
      exp_q[1] = {2'd1, 8'd2};
      exp_q[2] = {2'd2, 8'd3};
      exp_q[3] = {2'd3, 8'd4};
      O_ready = 1'b0;
      do_run(1, 2'd0);
      do_run(2, 2'd1);
      do_run(3, 2'd2);
      do_run(4, 2'd3);
      do_run(5, 2'd0);
      step();
      tests_run++;
      if (OVERFLOW !== 1'b1 || O_valid !== 1'b1 || O_data !== exp_q[0]) begin
         tests_failed++;
         $display("FAIL bp_full: ovf=%b valid=%b data=%h, required 1/1/%h", OVERFLOW, O_valid, O_data, exp_q[0]);
      end
      step();
      step();
      tests_run++;
      if (O_valid !== 1'b1 || O_data !== exp_q[0]) begin
         tests_failed++;
         $display("FAIL bp_stable: valid=%b data=%h, required 1/%h", O_valid, O_data, exp_q[0]);
      end
      CLEAR = 1'b1;
      step();
      tests_run++;
      if (OVERFLOW !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_clear: ovf=%b, required 0", OVERFLOW);
      end
      do_run(2, 2'd3);
      step();
      tests_run++;
      if (OVERFLOW !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_set_wins: ovf=%b, required 1", OVERFLOW);
      end
      CLEAR = 1'b0;
      step();
      tests_run++;
      if (OVERFLOW !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_sticky: ovf=%b, required 1", OVERFLOW);
      end
      CLEAR = 1'b1;
      step();
      CLEAR = 1'b0;
      tests_run++;
      if (OVERFLOW !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_clear2: ovf=%b, required 0", OVERFLOW);
      end
      O_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (O_valid !== 1'b1 || O_data !== exp_q[k]) begin
            tests_failed++;
            $display("FAIL bp_order[%0d]: valid=%b data=%h, required 1/%h", k, O_valid, O_data, exp_q[k]);
         end
         step();
      end
      tests_run++;
      if (O_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_drained: valid=%b, required 0", O_valid);
      end
   endtask

   task automatic test_saturation();
      O_ready = 1'b1;
      do_run(300, 2'b01);
      step();
      tests_run++;
      if (O_valid !== 1'b1 || O_data !== {2'b01, 8'd255}) begin
         tests_failed++;
         $display("FAIL saturation: valid=%b data=%h, required 1/%h", O_valid, O_data, {2'b01, 8'd255});
      end
      step();
      tests_run++;
      if (O_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL saturation_single: valid=%b, required 0", O_valid);
      end
   endtask

   task automatic test_full_push_pop();
      logic [9:0] exp_q [4];
      exp_q[0] = {2'd1, 8'd2};
      exp_q[1] = {2'd2, 8'd3};
      exp_q[2] = {2'd3, 8'd4};
      exp_q[3] = {2'd3, 8'd6};
      O_ready = 1'b0;
      do_run(1, 2'd0);
      do_run(2, 2'd1);
      do_run(3, 2'd2);
      do_run(4, 2'd3);
      do_run(6, 2'd3);
      O_ready = 1'b1;
      step();
      tests_run++;
      if (OVERFLOW !== 1'b0) begin
         tests_failed++;
         $display("FAIL fpp_no_overflow: ovf=%b, required 0", OVERFLOW);
      end
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (O_valid !== 1'b1 || O_data !== exp_q[k]) begin
            tests_failed++;
            $display("FAIL fpp_order[%0d]: valid=%b data=%h, required 1/%h", k, O_valid, O_data, exp_q[k]);
         end
         step();
      end
      tests_run++;
      if (O_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL fpp_drained: valid=%b, required 0", O_valid);
      end
   endtask

   task automatic test_reset_mid_run();
      O_ready = 1'b0;
      I  = 1'b1;
      I1 = 2'b11;
      repeat (5) step();
      RESETN = 1'b0;
      step();
      RESETN = 1'b1;
      I = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         tests_run++;
         if (O_valid !== 1'b0 || O_data !== 10'd0 || OVERFLOW !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_run[%0d]: valid=%b data=%h ovf=%b, required 0/000/0", k, O_valid, O_data, OVERFLOW);
         end
      end
   endtask

   task automatic test_gap();
      O_ready = 1'b0;
      I1 = 2'b01;
      I = 1'b1; step();
      I = 1'b1; step();
      I = 1'b0; step();
      I = 1'b1; step();
      I = 1'b0; step();
      step();
      tests_run++;
      if (O_valid !== 1'b1 || O_data !== {2'b01, 8'd2}) begin
         tests_failed++;
         $display("FAIL gap_first: valid=%b data=%h, required 1/%h", O_valid, O_data, {2'b01, 8'd2});
      end
      O_ready = 1'b1;
      step();
      tests_run++;
      if (O_valid !== 1'b1 || O_data !== {2'b01, 8'd1}) begin
         tests_failed++;
         $display("FAIL gap_second: valid=%b data=%h, required 1/%h", O_valid, O_data, {2'b01, 8'd1});
      end
      step();
      tests_run++;
      if (O_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL gap_drained: valid=%b, required 0", O_valid);
      end
   endtask

   initial begin
      RESETN  = 1'b0;
      I       = 1'b0;
      I1      = 2'b00;
      CLEAR   = 1'b0;
      O_ready = 1'b0;
      test_reset();
      test_single_run();
      test_backpressure();
      test_saturation();
      test_full_push_pop();
      test_reset_mid_run();
      test_gap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
